// File: rtl/mips16_pkg.sv
// Shared mips16 definitions used by the data-memory arbiter: the access
// FSM states, the owner of the access in flight, memory geometry and a
// small saturating-counter helper for the host starvation bound.
package mips16_pkg;

    localparam int DMEM_ADDR_W = 6;
    localparam int DATA_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ISS  = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } dmem_owner_t;

    // Next value of a counter that stops at max instead of wrapping.
    function automatic int sat_inc(input int cnt, input int max);
        if (cnt >= max) begin
            return max;
        end
        return cnt + 1;
    endfunction

endpackage

// File: rtl/mips16_dmem_pick.sv
// Winner selection for the shared data memory. The CPU has fixed priority
// over the host, except that the host is forced through once the CPU has
// taken STARVE_MAX grants in a row while the host was waiting. A debug
// halt makes the CPU ineligible altogether.
module mips16_dmem_pick
    import mips16_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic cpu_req,
    input  logic host_req,
    input  logic host_halt,
    output logic grant_valid,
    output logic grant_host
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             cpu_elig;
    logic             host_elig;
    logic             host_forced;

    assign cpu_elig    = cpu_req & ~host_halt;
    assign host_elig   = host_req;
    assign host_forced = (starve_cnt == CNT_W'(STARVE_MAX));

    // Combinational winner: host wins when it is alone or has been starved long enough.
    always_comb begin
        grant_valid = cpu_elig | host_elig;
        grant_host  = 1'b0;
        if (host_elig && (!cpu_elig || host_forced)) begin
            grant_host = 1'b1;
        end
    end

    // Count consecutive CPU grants taken while the host is waiting; only updated in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (!host_req || (grant_valid && grant_host)) begin
                starve_cnt <= '0;
            end else if (grant_valid && !grant_host) begin
                starve_cnt <= CNT_W'(sat_inc(int'(starve_cnt), STARVE_MAX));
            end
        end
    end

endmodule

// File: rtl/mips16_dmem_arbiter.sv
// Arbiter sharing the single-port 64x16 data memory between the mips16
// CPU load/store path and the host debug/loader port. Each access runs
// IDLE -> ISS -> RESP -> IDLE. Every memory-side output is a register
// loaded from the latched request, so nothing on the request inputs can
// reach the memory combinationally, and a requester may change its inputs
// freely once its access has been granted.
module mips16_dmem_arbiter
    import mips16_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = mips16_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    input  logic              host_halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_state_t state;
    dmem_owner_t owner;
    logic        lat_we;
    logic        grant_valid;
    logic        grant_host;

    mips16_dmem_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (state == IDLE),
        .cpu_req     (cpu_req),
        .host_req    (host_req),
        .host_halt   (host_halt),
        .grant_valid (grant_valid),
        .grant_host  (grant_host)
    );

    // The CPU is frozen from the moment it asks until the cycle its ack arrives.
    assign cpu_stall = cpu_req & ~cpu_ack;

    // Access sequencer: latch the winner in IDLE, strobe memory in ISS, ack and capture read data in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            lat_we     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            cpu_ack  <= 1'b0;
            host_ack <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_en <= 1'b1;
                        state  <= ISS;
                        if (grant_host) begin
                            owner     <= OWN_HOST;
                            lat_we    <= host_we;
                            mem_we    <= host_we;
                            mem_addr  <= host_addr;
                            mem_wdata <= host_wdata;
                        end else begin
                            owner     <= OWN_CPU;
                            lat_we    <= cpu_we;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                ISS: begin
                    state <= RESP;
                    if (owner == OWN_HOST) begin
                        host_ack <= 1'b1;
                    end else begin
                        cpu_ack <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (!lat_we) begin
                        if (owner == OWN_HOST) begin
                            host_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips16_dmem_arbiter.sv
// Self-checking bench for mips16_dmem_arbiter. A behavioural 64x16 memory
// with a one-cycle read sits on the memory side; a transaction-level
// reference (expected memory contents, expected rdata per port, expected
// grant order) predicts what each port should see.
module tb_mips16_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [5:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_stall;
    logic        host_req;
    logic        host_we;
    logic [5:0]  host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_ack;
    logic        host_halt;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem_array [64];
    logic        init_mem;

    logic [15:0] ref_mem [64];
    logic [15:0] exp_cpu_rdata;
    logic [15:0] exp_host_rdata;

    int checks;
    int errors;

    mips16_dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .host_halt  (host_halt),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known power-on contents; address 0 and 2 carry the directed-test values.
    function automatic logic [15:0] init_word(input int i);
        if (i == 0) return 16'h1234;
        if (i == 2) return 16'h9ABC;
        return 16'(i * 16'h0357 + 16'h0F0F);
    endfunction

    // Single-port synchronous-read memory model, preloaded while init_mem is high.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem_array[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) mem_array[mem_addr] <= mem_wdata;
            mem_rdata <= mem_array[mem_addr];
        end
    end

    // Hard stop in case some wait is ever unbounded.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic c_req, input logic c_we, input logic [5:0] c_addr,
                                 input logic [15:0] c_wdata, input logic h_req, input logic h_we,
                                 input logic [5:0] h_addr, input logic [15:0] h_wdata);
        cpu_req    = c_req;
        cpu_we     = c_we;
        cpu_addr   = c_addr;
        cpu_wdata  = c_wdata;
        host_req   = h_req;
        host_we    = h_we;
        host_addr  = h_addr;
        host_wdata = h_wdata;
    endtask

    // One complete access on one port, leaving the other port's inputs alone.
    task automatic port_access(input logic is_host, input logic we, input logic [5:0] addr,
                               input logic [15:0] wdata);
        logic found;
        found = 1'b0;
        if (is_host) begin
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if ((is_host && host_ack) || (!is_host && cpu_ack)) begin
                found = 1'b1;
                break;
            end
        end
        if (is_host) host_req = 1'b0;
        else         cpu_req  = 1'b0;
        checkOutput(is_host ? "host_access_ack" : "cpu_access_ack", 32'(found), 32'd1);
        if (found) begin
            if (we) ref_mem[addr] = wdata;
            else if (is_host) exp_host_rdata = ref_mem[addr];
            else exp_cpu_rdata = ref_mem[addr];
        end
        tick();
        checkOutput("access_cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
        checkOutput("access_host_rdata", 32'(host_rdata), 32'(exp_host_rdata));
    endtask

    // One random round: CPU, host or both request together from an idle arbiter.
    task automatic random_round;
        int          mode;
        logic        c_pend, h_pend;
        logic        c_we_r, h_we_r;
        logic [5:0]  c_ad, h_ad;
        logic [15:0] c_wd, h_wd;
        mode   = $urandom_range(0, 2);
        c_pend = (mode != 1);
        h_pend = (mode != 0);
        c_we_r = 1'($urandom_range(0, 1));
        h_we_r = 1'($urandom_range(0, 1));
        c_ad   = 6'($urandom_range(0, 15));
        h_ad   = 6'($urandom_range(0, 15));
        c_wd   = 16'($urandom);
        h_wd   = 16'($urandom);
        applyStimulus(c_pend, c_we_r, c_ad, c_wd, h_pend, h_we_r, h_ad, h_wd);
        for (int i = 0; i < 16 && (c_pend || h_pend); i++) begin
            tick();
            checkOutput("rand_single_ack", 32'(cpu_ack & host_ack), 32'd0);
            if (cpu_ack) begin
                checkOutput("rand_cpu_ack_expected", 32'(c_pend), 32'd1);
                if (c_we_r) ref_mem[c_ad] = c_wd;
                else exp_cpu_rdata = ref_mem[c_ad];
                c_pend  = 1'b0;
                cpu_req = 1'b0;
            end
            if (host_ack) begin
                checkOutput("rand_cpu_before_host", 32'(c_pend), 32'd0);
                if (h_we_r) ref_mem[h_ad] = h_wd;
                else exp_host_rdata = ref_mem[h_ad];
                h_pend   = 1'b0;
                host_req = 1'b0;
            end
        end
        checkOutput("rand_all_acked", 32'(c_pend | h_pend), 32'd0);
        cpu_req  = 1'b0;
        host_req = 1'b0;
        tick();
        checkOutput("rand_cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
        checkOutput("rand_host_rdata", 32'(host_rdata), 32'(exp_host_rdata));
    endtask

    initial begin
        logic        found;
        logic        want_host;
        int          waits;
        logic [15:0] saved_host;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        exp_cpu_rdata  = 16'h0;
        exp_host_rdata = 16'h0;

        // Reset held two cycles, memory preloaded meanwhile.
        $display("[TB] reset");
        rst       = 1'b1;
        init_mem  = 1'b1;
        host_halt = 1'b0;
        applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        tick();
        init_mem = 1'b0;
        tick();
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        checkOutput("rst_host_ack", 32'(host_ack), 32'd0);
        checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("rst_host_rdata", 32'(host_rdata), 32'd0);
        checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_mem_en_0", 32'(mem_en), 32'd0);
        tick();
        checkOutput("idle_mem_en_1", 32'(mem_en), 32'd0);

        // CPU read of address 2 with exact cycle timing.
        $display("[TB] cpu read latency");
        applyStimulus(1'b1, 1'b0, 6'd2, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        #1;
        checkOutput("lat_stall_n", 32'(cpu_stall), 32'd1);
        tick();
        checkOutput("lat_mem_en_n1", 32'(mem_en), 32'd1);
        checkOutput("lat_mem_we_n1", 32'(mem_we), 32'd0);
        checkOutput("lat_mem_addr_n1", 32'(mem_addr), 32'd2);
        checkOutput("lat_stall_n1", 32'(cpu_stall), 32'd1);
        checkOutput("lat_ack_n1", 32'(cpu_ack), 32'd0);
        tick();
        checkOutput("lat_ack_n2", 32'(cpu_ack), 32'd1);
        checkOutput("lat_stall_n2", 32'(cpu_stall), 32'd0);
        checkOutput("lat_mem_en_n2", 32'(mem_en), 32'd0);
        cpu_req = 1'b0;
        exp_cpu_rdata = ref_mem[2];
        tick();
        checkOutput("lat_rdata_n3", 32'(cpu_rdata), 32'h9ABC);
        checkOutput("lat_ack_n3", 32'(cpu_ack), 32'd0);

        // Host write then CPU read of the same word.
        $display("[TB] host write, cpu read");
        saved_host = host_rdata;
        port_access(1'b1, 1'b1, 6'd10, 16'h00A5);
        port_access(1'b0, 1'b0, 6'd10, 16'h0);
        checkOutput("hw_cpu_rdata", 32'(cpu_rdata), 32'h00A5);
        checkOutput("hw_host_rdata_kept", 32'(host_rdata), 32'(saved_host));

        // Both ports requesting continuously: host gets every fifth grant.
        $display("[TB] starvation bound");
        applyStimulus(1'b1, 1'b0, 6'd7, 16'h0, 1'b1, 1'b0, 6'd8, 16'h0);
        waits = 0;
        for (int k = 0; k < 10; k++) begin
            want_host = (waits == 4);
            found = 1'b0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (cpu_ack || host_ack) begin
                    found = 1'b1;
                    break;
                end
            end
            checkOutput($sformatf("starve_ack_seen_%0d", k), 32'(found), 32'd1);
            checkOutput($sformatf("starve_winner_host_%0d", k), 32'(host_ack), 32'(want_host));
            checkOutput($sformatf("starve_one_ack_%0d", k), 32'(cpu_ack & host_ack), 32'd0);
            waits = want_host ? 0 : waits + 1;
        end
        cpu_req  = 1'b0;
        host_req = 1'b0;
        exp_cpu_rdata  = ref_mem[7];
        exp_host_rdata = ref_mem[8];
        tick();
        checkOutput("starve_cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
        checkOutput("starve_host_rdata", 32'(host_rdata), 32'(exp_host_rdata));

        // Debug halt freezes the CPU while the host keeps working.
        $display("[TB] host halt");
        host_halt = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("halt_stall_held", 32'(cpu_stall), 32'd1);
            checkOutput("halt_no_cpu_ack", 32'(cpu_ack), 32'd0);
        end
        port_access(1'b1, 1'b0, 6'd0, 16'h0);
        checkOutput("halt_host_read0", 32'(host_rdata), 32'h1234);
        host_halt = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (cpu_ack) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("unhalt_cpu_ack", 32'(found), 32'd1);
        cpu_req = 1'b0;
        exp_cpu_rdata = ref_mem[3];
        tick();
        checkOutput("unhalt_cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));

        // Reset during ISS of a CPU write: memory still written, no ack.
        $display("[TB] reset during issue");
        applyStimulus(1'b1, 1'b1, 6'd5, 16'hBEEF, 1'b0, 1'b0, 6'd0, 16'h0);
        tick();
        checkOutput("rstiss_mem_en", 32'(mem_en), 32'd1);
        checkOutput("rstiss_mem_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        ref_mem[5] = 16'hBEEF;
        exp_cpu_rdata  = 16'h0;
        exp_host_rdata = 16'h0;
        for (int c = 0; c < 4; c++) begin
            checkOutput("rstiss_no_ack", 32'(cpu_ack), 32'd0);
            tick();
        end
        checkOutput("rstiss_rdata_cleared", 32'(host_rdata), 32'd0);
        port_access(1'b1, 1'b0, 6'd5, 16'h0);
        checkOutput("rstiss_host_read5", 32'(host_rdata), 32'hBEEF);

        // Reset during RESP of a CPU read: rdata cleared, no repeated ack.
        $display("[TB] reset during response");
        applyStimulus(1'b1, 1'b0, 6'd2, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        tick();
        tick();
        checkOutput("rstresp_ack", 32'(cpu_ack), 32'd1);
        rst = 1'b1;
        cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        exp_cpu_rdata  = 16'h0;
        exp_host_rdata = 16'h0;
        checkOutput("rstresp_no_ack", 32'(cpu_ack), 32'd0);
        checkOutput("rstresp_rdata", 32'(cpu_rdata), 32'd0);
        tick();

        // Randomized rounds against the reference.
        $display("[TB] random rounds");
        for (int r = 0; r < 40; r++) begin
            random_round();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
